// File: rtl/barcodescanner_nios_nios2_div_pkg.sv
// Shared definitions for the Nios II A-stage radix-2 restoring divider.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package barcodescanner_nios_nios2_div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 5;

   // Quotient delivered for a zero divisor, in both modes
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

   // FSM encoding kept as plain 2-bit constants for compatibility with older code
   typedef logic [1:0] div_state_t;
   localparam div_state_t IDLE = 2'd0;
   localparam div_state_t LOAD = 2'd1;
   localparam div_state_t CALC = 2'd2;
   localparam div_state_t FIX  = 2'd3;

endpackage

// File: rtl/barcodescanner_nios_nios2_div_step.sv
// One combinational restoring-division step: shift acc:q left, subtract divisor if it fits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, the caller decides when to register.
// Ports: acc/q/divisor in, acc_next/q_next out (all WIDTH bits).
module barcodescanner_nios_nios2_div_step
#(
   parameter int WIDTH = 32
)
(
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] shifted;
   logic           fits;

   // The shifted partial remainder needs one extra bit: acc < divisor < 2^WIDTH,
   // so 2*acc+1 can reach 2^WIDTH. The subtraction result always fits in WIDTH bits.
   assign shifted  = {acc, q[WIDTH-1]};
   assign fits     = (shifted >= {1'b0, divisor});
   assign acc_next = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
   assign q_next   = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/barcodescanner_nios_nios2_div_cell.sv
// Iterative div/divu cell for the Nios II A-stage: signed/unsigned quotient and remainder.
// Latency: done pulses WIDTH+2 cycles after the accepting start edge, independent of data.
// Backpressure: busy high while working; start is only sampled in IDLE, ignored otherwise.
// Ports: clk, reset (sync, active-high); A_div_start/signed/src1/src2 request inputs;
//        A_div_busy, A_div_done (1-cycle pulse), A_div_cell_result/rem (held until next FIX).
module barcodescanner_nios_nios2_div_cell
   import barcodescanner_nios_nios2_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             A_div_start,
   input  logic             A_div_signed,
   input  logic [WIDTH-1:0] A_div_src1,
   input  logic [WIDTH-1:0] A_div_src2,
   output logic             A_div_busy,
   output logic             A_div_done,
   output logic [WIDTH-1:0] A_div_cell_result,
   output logic [WIDTH-1:0] A_div_cell_rem
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       state;
   logic [CNT_W-1:0] count;

   // Operands and mode captured at the accepting start edge
   logic             sgn_l;
   logic [WIDTH-1:0] src1_l;
   logic [WIDTH-1:0] src2_l;

   // Working registers
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic             q_neg;
   logic             r_neg;
   logic             div0;

   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] quo_next;

   // Two's-complement magnitude. 0x80..0 negates to itself, which read as unsigned
   // is exactly 2^(WIDTH-1), so no extra bit is needed.
   assign mag1 = (sgn_l && src1_l[WIDTH-1]) ? -src1_l : src1_l;
   assign mag2 = (sgn_l && src2_l[WIDTH-1]) ? -src2_l : src2_l;

   barcodescanner_nios_nios2_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc      (acc),
      .q        (quo),
      .divisor  (dvsr),
      .acc_next (acc_next),
      .q_next   (quo_next)
   );

   assign A_div_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         count             <= '0;
         sgn_l             <= 1'b0;
         src1_l            <= '0;
         src2_l            <= '0;
         acc               <= '0;
         quo               <= '0;
         dvsr              <= '0;
         q_neg             <= 1'b0;
         r_neg             <= 1'b0;
         div0              <= 1'b0;
         A_div_done        <= 1'b0;
         A_div_cell_result <= '0;
         A_div_cell_rem    <= '0;
      end else begin
         A_div_done <= 1'b0;
         case (state)
            IDLE: begin
               if (A_div_start) begin
                  sgn_l  <= A_div_signed;
                  src1_l <= A_div_src1;
                  src2_l <= A_div_src2;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               quo   <= mag1;
               dvsr  <= mag2;
               acc   <= '0;
               count <= '0;
               q_neg <= sgn_l & (src1_l[WIDTH-1] ^ src2_l[WIDTH-1]);
               r_neg <= sgn_l & src1_l[WIDTH-1];
               div0  <= (src2_l == '0);
               state <= CALC;
            end
            CALC: begin
               acc <= acc_next;
               quo <= quo_next;
               if (count == LAST_CNT) begin
                  state <= FIX;
               end else begin
                  count <= count + 1'b1;
               end
            end
            FIX: begin
               // A zero divisor bypasses the sign fix-up: the iteration result would
               // otherwise be negated for a negative dividend.
               if (div0) begin
                  A_div_cell_result <= {WIDTH{1'b1}};
                  A_div_cell_rem    <= src1_l;
               end else begin
                  A_div_cell_result <= q_neg ? -quo : quo;
                  A_div_cell_rem    <= r_neg ? -acc : acc;
               end
               A_div_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_barcodescanner_nios_nios2_div_cell.sv
// Directed and random checks of the div/divu cell against hand values and a reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_barcodescanner_nios_nios2_div_cell;

   logic        clk;
   logic        reset;
   logic        A_div_start;
   logic        A_div_signed;
   logic [31:0] A_div_src1;
   logic [31:0] A_div_src2;
   logic        A_div_busy;
   logic        A_div_done;
   logic [31:0] A_div_cell_result;
   logic [31:0] A_div_cell_rem;

   int checks = 0;
   int errors = 0;

   barcodescanner_nios_nios2_div_cell dut (
      .clk               (clk),
      .reset             (reset),
      .A_div_start       (A_div_start),
      .A_div_signed      (A_div_signed),
      .A_div_src1        (A_div_src1),
      .A_div_src2        (A_div_src2),
      .A_div_busy        (A_div_busy),
      .A_div_done        (A_div_done),
      .A_div_cell_result (A_div_cell_result),
      .A_div_cell_rem    (A_div_cell_rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a request now, let the next rising edge accept it, then drop start.
   task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      A_div_start  = 1'b1;
      A_div_signed = sgn;
      A_div_src1   = a;
      A_div_src2   = b;
      @(posedge clk);
      #1;
      A_div_start  = 1'b0;
   endtask

   // Count rising edges until done is seen; bounded so a stuck DUT cannot hang the run.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!A_div_done && n < 100);
   endtask

   task automatic do_op(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
      int n;
      start_op(sgn, a, b);
      chk({tag, " busy"}, {31'd0, A_div_busy}, 32'd1);
      wait_done(n);
      chk({tag, " latency"}, n, 32'd34);
      chk({tag, " result"}, A_div_cell_result, eq);
      chk({tag, " rem"}, A_div_cell_rem, er);
      @(posedge clk);
      #1;
      chk({tag, " done pulse width"}, {31'd0, A_div_done}, 32'd0);
   endtask

   // Reference: language-level division truncates toward zero, remainder follows dividend.
   function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sgn) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   initial begin
      int n;
      int pulses;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eq;
      logic [31:0] er;
      bit          sgn;

      reset        = 1'b1;
      A_div_start  = 1'b0;
      A_div_signed = 1'b0;
      A_div_src1   = '0;
      A_div_src2   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, A_div_busy}, 32'd0);
      chk("reset done", {31'd0, A_div_done}, 32'd0);
      chk("reset result", A_div_cell_result, 32'd0);
      chk("reset rem", A_div_cell_rem, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Main function and boundary cases
      do_op("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      do_op("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
      do_op("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
      do_op("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
      do_op("divu by 0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
      do_op("div by 0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
      do_op("div neg by 0", 1'b1, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF6);
      do_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      do_op("div min/2", 1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0);
      do_op("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
      do_op("divu max/max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
      do_op("divu 0/5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0);
      do_op("divu 7/100", 1'b0, 32'd7, 32'd100, 32'd0, 32'd7);

      // Start re-pulsed while busy must be ignored
      start_op(1'b0, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      start_op(1'b1, 32'd999, 32'd3);
      wait_done(n);
      chk("busy restart latency", n, 32'd28);
      chk("busy restart result", A_div_cell_result, 32'd14);
      chk("busy restart rem", A_div_cell_rem, 32'd2);

      // Start in the done cycle is accepted; the next op runs the full latency
      start_op(1'b0, 32'd1000, 32'd33);
      chk("b2b busy", {31'd0, A_div_busy}, 32'd1);
      wait_done(n);
      chk("b2b latency", n, 32'd34);
      chk("b2b result", A_div_cell_result, 32'd30);
      chk("b2b rem", A_div_cell_rem, 32'd10);
      @(posedge clk);
      #1;

      // Reset in the middle of CALC aborts without a done pulse
      start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
      repeat (11) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort busy", {31'd0, A_div_busy}, 32'd0);
      chk("abort done", {31'd0, A_div_done}, 32'd0);
      chk("abort result", A_div_cell_result, 32'd0);
      chk("abort rem", A_div_cell_rem, 32'd0);
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (A_div_done) pulses++;
      end
      chk("abort no done", pulses, 32'd0);
      do_op("after abort", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);

      // Random operands against the reference model
      for (int i = 0; i < 200; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(0, 20));
            1:       b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         ref_div(sgn, a, b, eq, er);
         start_op(sgn, a, b);
         wait_done(n);
         chk("rand latency", n, 32'd34);
         chk("rand result", A_div_cell_result, eq);
         chk("rand rem", A_div_cell_rem, er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
